alu_issue_ctrl: RTL and testbench

ALU_ISSUE_CTRL -- requirements
Module: alu_issue_ctrl

---
 rtl/alu_issue_ctrl.sv | 115 +++++++++++
 tb/tb_alu_issue_ctrl.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_ctrl.sv
// Single-issue ALU sequencer: decodes one instruction, drives the external ALU and returns its result.
// Optional sll/srl decode is enabled by defining ALU_ISSUE_SHIFT_EN.
module alu_issue_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic        instr_valid,
  output logic        instr_ready,
  input  logic [5:0]  opcode,
  input  logic [5:0]  funct,
  input  logic [4:0]  shamt,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  output logic [31:0] alu_in1,
  output logic [31:0] alu_in2,
  output logic [3:0]  alu_control,
  input  logic [31:0] alu_out,
  input  logic        alu_zero,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [31:0] res_data,
  output logic        branch_taken,
  output logic        illegal
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXEC,
    S_RESP
  } state_t;

  state_t     state, state_nxt;
  logic       accept;
  logic       dec_legal, dec_shift, dec_branch;
  logic [3:0] dec_ctrl;
  logic       is_branch;

  assign instr_ready = (state == S_IDLE);
  assign res_valid   = (state == S_RESP);
  assign accept      = instr_valid & instr_ready;

  always_comb begin
    dec_legal  = 1'b0;
    dec_shift  = 1'b0;
    dec_branch = 1'b0;
    dec_ctrl   = '0;
    case (opcode)
      6'b000000: begin
        case (funct)
          6'b100100: begin dec_legal = 1'b1; dec_ctrl = 4'b0000; end
          6'b100101: begin dec_legal = 1'b1; dec_ctrl = 4'b0001; end
          6'b100000: begin dec_legal = 1'b1; dec_ctrl = 4'b0010; end
          6'b101010: begin dec_legal = 1'b1; dec_ctrl = 4'b0111; end
`ifdef ALU_ISSUE_SHIFT_EN
          6'b000000: begin dec_legal = 1'b1; dec_shift = 1'b1; dec_ctrl = 4'b1111; end
          6'b000010: begin dec_legal = 1'b1; dec_shift = 1'b1; dec_ctrl = 4'b1110; end
`endif
          default: ;
        endcase
      end
      6'b100011, 6'b101011: begin dec_legal = 1'b1; dec_ctrl = 4'b0010; end
      6'b000100: begin dec_legal = 1'b1; dec_branch = 1'b1; dec_ctrl = 4'b0110; end
      6'b000101: begin dec_legal = 1'b1; dec_branch = 1'b1; dec_ctrl = 4'b1011; end
      default: ;
    endcase
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (accept) state_nxt = dec_legal ? S_EXEC : S_RESP;
      S_EXEC: state_nxt = S_RESP;
      S_RESP: if (res_ready) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // alu_zero is only meaningful for branches; the ALU leaves it stale otherwise.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= S_IDLE;
      alu_in1      <= '0;
      alu_in2      <= '0;
      alu_control  <= '0;
      is_branch    <= 1'b0;
      res_data     <= '0;
      branch_taken <= 1'b0;
      illegal      <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        S_IDLE: begin
          if (accept) begin
            if (dec_legal) begin
              alu_in1     <= dec_shift ? rt_val : rs_val;
              alu_in2     <= dec_shift ? {21'b0, shamt, 6'b0} : rt_val;
              alu_control <= dec_ctrl;
              is_branch   <= dec_branch;
              illegal     <= 1'b0;
            end else begin
              illegal      <= 1'b1;
              res_data     <= '0;
              branch_taken <= 1'b0;
            end
          end
        end
        S_EXEC: begin
          res_data     <= is_branch ? '0 : alu_out;
          branch_taken <= is_branch & alu_zero;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Self-checking bench for alu_issue_ctrl: directed vector table, reset abort case, randomized traffic.
// Compile with the same ALU_ISSUE_SHIFT_EN setting as the design.
module tb_alu_issue_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        instr_valid;
  logic        instr_ready;
  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic [4:0]  shamt;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic [31:0] alu_in1;
  logic [31:0] alu_in2;
  logic [3:0]  alu_control;
  logic [31:0] alu_out;
  logic        alu_zero = 1'b0;
  logic        res_valid;
  logic        res_ready;
  logic [31:0] res_data;
  logic        branch_taken;
  logic        illegal;

  int unsigned total  = 0;
  int unsigned passed = 0;

  logic [3:0]  last_ctrl = '0;
  logic [31:0] last_in1  = '0;
  logic [31:0] last_in2  = '0;

  alu_issue_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .opcode      (opcode),
    .funct       (funct),
    .shamt       (shamt),
    .rs_val      (rs_val),
    .rt_val      (rt_val),
    .alu_in1     (alu_in1),
    .alu_in2     (alu_in2),
    .alu_control (alu_control),
    .alu_out     (alu_out),
    .alu_zero    (alu_zero),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .res_data    (res_data),
    .branch_taken(branch_taken),
    .illegal     (illegal)
  );

  always #5 clk = ~clk;

  // Behavioural ALU; zero flag only updates on branch codes and otherwise keeps its old value.
  always_comb begin
    alu_out = '0;
    case (alu_control)
      4'b0000: alu_out = alu_in1 & alu_in2;
      4'b0001: alu_out = alu_in1 | alu_in2;
      4'b0010: alu_out = alu_in1 + alu_in2;
      4'b0111: alu_out = ($signed(alu_in1) < $signed(alu_in2)) ? 32'd1 : 32'd0;
      4'b1111: alu_out = alu_in1 << alu_in2[10:6];
      4'b1110: alu_out = alu_in1 >> alu_in2[10:6];
      4'b0110, 4'b1011: alu_out = alu_in1 - alu_in2;
      default: alu_out = '0;
    endcase
  end

  always @(alu_in1 or alu_in2 or alu_control) begin
    if (alu_control == 4'b0110) alu_zero = (alu_in1 == alu_in2);
    else if (alu_control == 4'b1011) alu_zero = (alu_in1 != alu_in2);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
  endtask

  typedef struct {
    logic [5:0]  op;
    logic [5:0]  fn;
    logic [4:0]  sh;
    logic [31:0] rs;
    logic [31:0] rt;
    int unsigned stall;
    logic        ill;
    logic [3:0]  ctrl;
    logic [31:0] in1;
    logic [31:0] in2;
    logic [31:0] data;
    logic        br;
  } vec_t;

  // Reference semantics straight from the instruction definitions.
  function automatic void ref_model(input logic [5:0] op, input logic [5:0] fn, input logic [4:0] sh,
                                    input logic [31:0] rs, input logic [31:0] rt,
                                    output logic ill, output logic [3:0] ctrl, output logic [31:0] in1,
                                    output logic [31:0] in2, output logic [31:0] data, output logic br);
    ill = 1'b0; ctrl = 4'b0000; in1 = rs; in2 = rt; data = 32'd0; br = 1'b0;
    if (op == 6'd0) begin
      if (fn == 6'b100100) begin ctrl = 4'b0000; data = rs & rt; end
      else if (fn == 6'b100101) begin ctrl = 4'b0001; data = rs | rt; end
      else if (fn == 6'b100000) begin ctrl = 4'b0010; data = rs + rt; end
      else if (fn == 6'b101010) begin ctrl = 4'b0111; data = ($signed(rs) < $signed(rt)) ? 32'd1 : 32'd0; end
`ifdef ALU_ISSUE_SHIFT_EN
      else if (fn == 6'b000000) begin ctrl = 4'b1111; in1 = rt; in2 = 32'(sh) * 32'd64; data = rt << sh; end
      else if (fn == 6'b000010) begin ctrl = 4'b1110; in1 = rt; in2 = 32'(sh) * 32'd64; data = rt >> sh; end
`endif
      else ill = 1'b1;
    end
    else if (op == 6'b100011 || op == 6'b101011) begin ctrl = 4'b0010; data = rs + rt; end
    else if (op == 6'b000100) begin ctrl = 4'b0110; br = (rs == rt); end
    else if (op == 6'b000101) begin ctrl = 4'b1011; br = (rs != rt); end
    else ill = 1'b1;
  endfunction

  task automatic issue(input vec_t v);
    int unsigned n;
    logic [3:0]  e_ctrl;
    logic [31:0] e_in1, e_in2, e_data;
    logic        e_br;
    if (v.ill) begin
      e_ctrl = last_ctrl; e_in1 = last_in1; e_in2 = last_in2; e_data = 32'd0; e_br = 1'b0;
    end else begin
      e_ctrl = v.ctrl; e_in1 = v.in1; e_in2 = v.in2; e_data = v.data; e_br = v.br;
    end
    @(negedge clk);
    n = 0;
    while (!instr_ready && n < 20) begin @(negedge clk); n++; end
    chk("ready_idle", 32'(instr_ready), 32'd1);
    opcode = v.op; funct = v.fn; shamt = v.sh; rs_val = v.rs; rt_val = v.rt;
    instr_valid = 1'b1;
    @(posedge clk);
    #1 instr_valid = 1'b0;
    @(negedge clk);
    chk("ready_busy", 32'(instr_ready), 32'd0);
    if (v.ill) begin
      chk("ill_latency_valid", 32'(res_valid), 32'd1);
    end else begin
      chk("exec_valid_low", 32'(res_valid), 32'd0);
      chk("exec_in1", alu_in1, e_in1);
      chk("exec_in2", alu_in2, e_in2);
      @(negedge clk);
      chk("legal_latency_valid", 32'(res_valid), 32'd1);
    end
    chk("alu_control", 32'(alu_control), 32'(e_ctrl));
    chk("alu_in1_hold", alu_in1, e_in1);
    chk("illegal", 32'(illegal), 32'(v.ill));
    chk("res_data", res_data, e_data);
    chk("branch_taken", 32'(branch_taken), 32'(e_br));
    for (int unsigned i = 0; i < v.stall; i++) begin
      @(negedge clk);
      chk("stall_valid", 32'(res_valid), 32'd1);
      chk("stall_ready", 32'(instr_ready), 32'd0);
      chk("stall_data", res_data, e_data);
      chk("stall_br", 32'(branch_taken), 32'(e_br));
      chk("stall_ill", 32'(illegal), 32'(v.ill));
    end
    res_ready = 1'b1;
    @(posedge clk);
    #1 res_ready = 1'b0;
    @(negedge clk);
    chk("release_valid", 32'(res_valid), 32'd0);
    chk("release_ready", 32'(instr_ready), 32'd1);
    last_ctrl = e_ctrl; last_in1 = e_in1; last_in2 = e_in2;
  endtask

  vec_t vt[$];

  function automatic vec_t mk(input logic [5:0] op, input logic [5:0] fn, input logic [4:0] sh,
                              input logic [31:0] rs, input logic [31:0] rt, input int unsigned stall,
                              input logic ill, input logic [3:0] ctrl, input logic [31:0] in1,
                              input logic [31:0] in2, input logic [31:0] data, input logic br);
    vec_t v;
    v.op = op; v.fn = fn; v.sh = sh; v.rs = rs; v.rt = rt; v.stall = stall;
    v.ill = ill; v.ctrl = ctrl; v.in1 = in1; v.in2 = in2; v.data = data; v.br = br;
    return v;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    reset = 1'b1; instr_valid = 1'b0; res_ready = 1'b0;
    opcode = '0; funct = '0; shamt = '0; rs_val = '0; rt_val = '0;

    vt.push_back(mk(6'd0, 6'b100000, 5'd0, 32'd5, 32'd7, 5, 1'b0, 4'b0010, 32'd5, 32'd7, 32'd12, 1'b0));
    vt.push_back(mk(6'b000100, 6'd0, 5'd0, 32'd9, 32'd9, 0, 1'b0, 4'b0110, 32'd9, 32'd9, 32'd0, 1'b1));
    vt.push_back(mk(6'b000101, 6'd0, 5'd0, 32'd1, 32'd2, 1, 1'b0, 4'b1011, 32'd1, 32'd2, 32'd0, 1'b1));
`ifdef ALU_ISSUE_SHIFT_EN
    vt.push_back(mk(6'd0, 6'b000000, 5'd4, 32'hdead, 32'd1, 0, 1'b0, 4'b1111, 32'd1, 32'h100, 32'd16, 1'b0));
    vt.push_back(mk(6'd0, 6'b000010, 5'd8, 32'd7, 32'h8000_0000, 0, 1'b0, 4'b1110, 32'h8000_0000,
                    32'h200, 32'h0080_0000, 1'b0));
`else
    vt.push_back(mk(6'd0, 6'b000000, 5'd4, 32'hdead, 32'd1, 0, 1'b1, 4'b0, 32'd0, 32'd0, 32'd0, 1'b0));
    vt.push_back(mk(6'd0, 6'b000010, 5'd8, 32'd7, 32'h8000_0000, 0, 1'b1, 4'b0, 32'd0, 32'd0, 32'd0, 1'b0));
`endif
    vt.push_back(mk(6'b111111, 6'd0, 5'd0, 32'd3, 32'd4, 2, 1'b1, 4'b0, 32'd0, 32'd0, 32'd0, 1'b0));
    vt.push_back(mk(6'd0, 6'b100100, 5'd0, 32'hff00_ff00, 32'h0f0f_0f0f, 0, 1'b0, 4'b0000,
                    32'hff00_ff00, 32'h0f0f_0f0f, 32'h0f00_0f00, 1'b0));
    vt.push_back(mk(6'd0, 6'b100101, 5'd0, 32'hf0, 32'h0f, 0, 1'b0, 4'b0001, 32'hf0, 32'h0f, 32'hff, 1'b0));
    vt.push_back(mk(6'd0, 6'b101010, 5'd0, 32'hffff_fffd, 32'd2, 0, 1'b0, 4'b0111, 32'hffff_fffd, 32'd2,
                    32'd1, 1'b0));
    vt.push_back(mk(6'd0, 6'b111111, 5'd0, 32'd1, 32'd1, 0, 1'b1, 4'b0, 32'd0, 32'd0, 32'd0, 1'b0));
    vt.push_back(mk(6'b100011, 6'd0, 5'd0, 32'h1000, 32'h24, 0, 1'b0, 4'b0010, 32'h1000, 32'h24, 32'h1024, 1'b0));
    vt.push_back(mk(6'b101011, 6'd0, 5'd0, 32'hffff_ffff, 32'd1, 0, 1'b0, 4'b0010, 32'hffff_ffff, 32'd1,
                    32'd0, 1'b0));
    vt.push_back(mk(6'b000100, 6'd0, 5'd0, 32'd4, 32'd5, 0, 1'b0, 4'b0110, 32'd4, 32'd5, 32'd0, 1'b0));
    vt.push_back(mk(6'b000101, 6'd0, 5'd0, 32'd6, 32'd6, 0, 1'b0, 4'b1011, 32'd6, 32'd6, 32'd0, 1'b0));

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", 32'(instr_ready), 32'd1);
    chk("rst_valid", 32'(res_valid), 32'd0);
    chk("rst_data", res_data, 32'd0);
    chk("rst_ctrl", 32'(alu_control), 32'd0);
    chk("rst_in1", alu_in1, 32'd0);
    chk("rst_in2", alu_in2, 32'd0);
    reset = 1'b0;

    for (int i = 0; i < vt.size(); i++) issue(vt[i]);

    // Reset pulse while an add is in EXEC: result must be dropped.
    @(negedge clk);
    opcode = 6'd0; funct = 6'b100000; rs_val = 32'd2; rt_val = 32'd3; instr_valid = 1'b1;
    @(posedge clk);
    #1 instr_valid = 1'b0;
    @(negedge clk);
    chk("pre_rst_in1", alu_in1, 32'd2);
    reset = 1'b1;
    #1;
    chk("arst_ready", 32'(instr_ready), 32'd1);
    chk("arst_valid", 32'(res_valid), 32'd0);
    chk("arst_data", res_data, 32'd0);
    chk("arst_br", 32'(branch_taken), 32'd0);
    chk("arst_ill", 32'(illegal), 32'd0);
    chk("arst_in1", alu_in1, 32'd0);
    chk("arst_in2", alu_in2, 32'd0);
    chk("arst_ctrl", 32'(alu_control), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    last_ctrl = '0; last_in1 = '0; last_in2 = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("post_rst_no_valid", 32'(res_valid), 32'd0);
      chk("post_rst_ready", 32'(instr_ready), 32'd1);
    end

    for (int unsigned k = 0; k < 150; k++) begin
      logic [5:0] ops [9] = '{6'd0, 6'd0, 6'd0, 6'd0, 6'b100011, 6'b101011, 6'b000100, 6'b000101, 6'd0};
      logic [5:0] fns [7] = '{6'b100100, 6'b100101, 6'b100000, 6'b101010, 6'b000000, 6'b000010, 6'd0};
      v.op = ops[$urandom_range(0, 8)];
      if (k % 9 == 8) v.op = 6'($urandom);
      v.fn = fns[$urandom_range(0, 6)];
      if (k % 7 == 6) v.fn = 6'($urandom);
      v.sh = 5'($urandom);
      v.rs = $urandom;
      v.rt = ($urandom_range(0, 3) == 0) ? v.rs : $urandom;
      v.stall = $urandom_range(0, 3);
      ref_model(v.op, v.fn, v.sh, v.rs, v.rt, v.ill, v.ctrl, v.in1, v.in2, v.data, v.br);
      issue(v);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
